// File: rtl/keypad_digit_encoder.sv
// 4x4 active-low matrix keypad scanner with scan-level debounce.
// Each accepted press yields one digit_out/load strobe for the lock entry port.
module keypad_digit_encoder #(
    parameter int SCAN_DIV       = 1000,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] row_in,
    output logic [3:0] col_out,
    output logic [3:0] digit_out,
    output logic       load,
    output logic       key_held
);

    localparam int DW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam int CW = $clog2(DEBOUNCE_SCANS + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DEBOUNCE,
        S_HELD,
        S_RELEASE
    } state_t;

    state_t          r_state;
    state_t          w_state_nx;
    logic [DW-1:0]   r_dwell;
    logic [1:0]      r_col;
    logic [1:0]      r_acc_cnt;
    logic [3:0]      r_acc_code;
    logic [CW-1:0]   r_cnt;
    logic [CW-1:0]   w_cnt_nx;
    logic [3:0]      r_cand;
    logic [3:0]      w_cand_nx;
    logic [3:0]      r_digit;
    logic            r_load;
    logic            w_accept;

    logic            w_dwell_last;
    logic            w_scan_end;
    logic [3:0]      w_hit;
    logic [2:0]      w_col_cnt;
    logic [1:0]      w_col_row;
    logic [2:0]      w_sum;
    logic [1:0]      w_tot;
    logic [3:0]      w_code;
    logic            w_none;
    logic            w_single;
    logic            w_last_cnt;

    assign w_dwell_last = (r_dwell == DW'(SCAN_DIV - 1));
    assign w_scan_end   = w_dwell_last && (r_col == 2'd3);
    assign w_hit        = ~row_in;

    // Rows seen low in the current column; the row index only matters when exactly one is low.
    always_comb begin
        w_col_cnt = 3'd0;
        w_col_row = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (w_hit[i]) begin
                w_col_cnt = w_col_cnt + 3'd1;
                w_col_row = 2'(i);
            end
        end
    end

    // Key count saturates at 2: anything beyond one key is simply MULTI.
    assign w_sum    = {1'b0, r_acc_cnt} + w_col_cnt;
    assign w_tot    = (w_sum >= 3'd2) ? 2'd2 : w_sum[1:0];
    assign w_code   = (r_acc_cnt == 2'd0) ? {w_col_row, r_col} : r_acc_code;
    assign w_none   = (w_tot == 2'd0);
    assign w_single = (w_tot == 2'd1);

    assign w_last_cnt = (r_cnt == CW'(DEBOUNCE_SCANS - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_dwell    <= '0;
            r_col      <= 2'd0;
            r_acc_cnt  <= 2'd0;
            r_acc_code <= 4'd0;
        end else if (w_dwell_last) begin
            r_dwell <= '0;
            r_col   <= r_col + 2'd1;
            if (w_scan_end) begin
                r_acc_cnt  <= 2'd0;
                r_acc_code <= 4'd0;
            end else begin
                r_acc_cnt  <= w_tot;
                r_acc_code <= w_code;
            end
        end else begin
            r_dwell <= r_dwell + DW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_cand  <= 4'd0;
            r_digit <= 4'd0;
            r_load  <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_cnt   <= w_cnt_nx;
            r_cand  <= w_cand_nx;
            r_load  <= w_accept;
            if (w_accept) begin
                r_digit <= w_cand_nx;
            end
        end
    end

    // The state machine only moves on a scan end; in between it holds.
    always_comb begin
        w_state_nx = r_state;
        w_cnt_nx   = r_cnt;
        w_cand_nx  = r_cand;
        w_accept   = 1'b0;
        if (w_scan_end) begin
            unique case (r_state)
                S_IDLE: begin
                    if (w_single) begin
                        w_cand_nx = w_code;
                        if (DEBOUNCE_SCANS == 1) begin
                            w_accept   = 1'b1;
                            w_cnt_nx   = '0;
                            w_state_nx = S_HELD;
                        end else begin
                            w_cnt_nx   = CW'(1);
                            w_state_nx = S_DEBOUNCE;
                        end
                    end
                end
                S_DEBOUNCE: begin
                    if (w_single && (w_code == r_cand)) begin
                        if (w_last_cnt) begin
                            w_accept   = 1'b1;
                            w_cnt_nx   = '0;
                            w_state_nx = S_HELD;
                        end else begin
                            w_cnt_nx = r_cnt + CW'(1);
                        end
                    end else if (w_single) begin
                        w_cand_nx = w_code;
                        w_cnt_nx  = CW'(1);
                    end else begin
                        w_cnt_nx   = '0;
                        w_state_nx = S_IDLE;
                    end
                end
                S_HELD: begin
                    if (w_none) begin
                        if (DEBOUNCE_SCANS == 1) begin
                            w_cnt_nx   = '0;
                            w_state_nx = S_IDLE;
                        end else begin
                            w_cnt_nx   = CW'(1);
                            w_state_nx = S_RELEASE;
                        end
                    end
                end
                S_RELEASE: begin
                    if (!w_none) begin
                        w_cnt_nx   = '0;
                        w_state_nx = S_HELD;
                    end else if (w_last_cnt) begin
                        w_cnt_nx   = '0;
                        w_state_nx = S_IDLE;
                    end else begin
                        w_cnt_nx = r_cnt + CW'(1);
                    end
                end
                default: begin
                    w_cnt_nx   = '0;
                    w_state_nx = S_IDLE;
                end
            endcase
        end
    end

    assign col_out   = ~(4'b0001 << r_col);
    assign digit_out = r_digit;
    assign load      = r_load;
    assign key_held  = (r_state == S_HELD) || (r_state == S_RELEASE);

endmodule

// File: tb/tb_keypad_digit_encoder.sv
// Directed bench for keypad_digit_encoder with SCAN_DIV=4, DEBOUNCE_SCANS=3 (16-cycle scans).
// A behavioural keypad closes row/column contacts from the pressed-key mask and col_out.
module tb_keypad_digit_encoder;

    localparam int SD   = 4;
    localparam int DB   = 3;
    localparam int SCAN = 4 * SD;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] row_in;
    logic [3:0] col_out;
    logic [3:0] digit_out;
    logic       load;
    logic       key_held;

    logic [15:0] keys = 16'h0000;
    int          cyc = 0;
    int          n_vec = 0;
    int          n_err = 0;
    int          n_loads = 0;
    int          last_load_cyc = -1;
    logic [3:0]  dig_q[$];

    keypad_digit_encoder #(.SCAN_DIV(SD), .DEBOUNCE_SCANS(DB)) dut (
        .clk      (clk),
        .reset    (reset),
        .row_in   (row_in),
        .col_out  (col_out),
        .digit_out(digit_out),
        .load     (load),
        .key_held (key_held)
    );

    always #5 clk = ~clk;

    always_comb begin
        row_in = 4'hF;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (keys[4*r+c] && !col_out[c]) row_in[r] = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (load) begin
            n_loads++;
            last_load_cyc = cyc;
            dig_q.push_back(digit_out);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            cyc++;
        end
    endtask

    task automatic goto_scan();
        while (cyc % SCAN != 0) tick(1);
    endtask

    int          n0;
    int          s;
    logic [3:0]  ec;
    int          seq[4] = '{4, 3, 2, 1};

    initial begin
        // 1: reset values and idle scanning
        reset = 1'b1;
        tick(2);
        chk("rst_col", col_out, 4'b1110);
        chk("rst_digit", digit_out, 0);
        chk("rst_load", load, 0);
        chk("rst_held", key_held, 0);
        reset = 1'b0;
        cyc = 0;
        for (int i = 0; i < 40; i++) begin
            ec = 4'b1111;
            ec[(cyc / SD) % 4] = 1'b0;
            chk("idle_col", col_out, ec);
            chk("idle_load", load, 0);
            tick(1);
        end
        chk("idle_loads", n_loads, 0);

        // 2: steady key (1,2); the load lands in the 49th cycle of the press
        goto_scan();
        n0 = n_loads;
        s = cyc;
        keys = 16'h0001 << 6;
        tick(300);
        chk("t2_loads", n_loads - n0, 1);
        chk("t2_latency", last_load_cyc - s + 1, 49);
        chk("t2_digit", digit_out, 6);
        chk("t2_held", key_held, 1);
        keys = 16'h0000;
        tick(51);
        chk("t2_held_last", key_held, 1);
        tick(1);
        chk("t2_released", key_held, 0);
        chk("t2_loads_end", n_loads - n0, 1);

        // 3: one-scan bounce on (0,1)
        goto_scan();
        n0 = n_loads;
        for (int i = 0; i < 5; i++) begin
            keys = 16'h0001 << 1;
            tick(SCAN);
            keys = 16'h0000;
            tick(SCAN);
        end
        chk("t3_loads", n_loads - n0, 0);
        chk("t3_digit", digit_out, 6);
        chk("t3_held", key_held, 0);

        // 4: two keys together, then only (2,3)
        goto_scan();
        n0 = n_loads;
        keys = 16'h0801;
        tick(5 * SCAN);
        chk("t4_multi_loads", n_loads - n0, 0);
        chk("t4_multi_held", key_held, 0);
        keys = 16'h0800;
        s = cyc;
        tick(49);
        chk("t4_loads", n_loads - n0, 1);
        chk("t4_latency", last_load_cyc - s + 1, 49);
        chk("t4_digit", digit_out, 11);
        keys = 16'h0000;
        tick(4 * SCAN);
        chk("t4_released", key_held, 0);

        // 5: code entry 4,3,2,1
        n0 = n_loads;
        for (int k = 0; k < 4; k++) begin
            goto_scan();
            keys = 16'h0001 << seq[k];
            tick(4 * SCAN);
            chk("t5_held", key_held, 1);
            keys = 16'h0000;
            tick(4 * SCAN);
            chk("t5_rel", key_held, 0);
        end
        chk("t5_loads", n_loads - n0, 4);
        for (int k = 0; k < 4; k++) begin
            if (n0 + k < dig_q.size()) chk("t5_digit", dig_q[n0+k], seq[k]);
            else chk("t5_digit_missing", n0 + k, dig_q.size());
        end

        // 6: reset in the middle of debouncing (3,3)
        goto_scan();
        n0 = n_loads;
        keys = 16'h0001 << 15;
        tick(2 * SCAN);
        chk("t6_pre_loads", n_loads - n0, 0);
        chk("t6_pre_held", key_held, 0);
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
        cyc = 0;
        chk("t6_rst_col", col_out, 4'b1110);
        chk("t6_rst_digit", digit_out, 0);
        chk("t6_rst_load", load, 0);
        chk("t6_rst_held", key_held, 0);
        tick(3 * SCAN - 1);
        chk("t6_early_load", load, 0);
        chk("t6_early_loads", n_loads - n0, 0);
        tick(1);
        chk("t6_load", load, 1);
        chk("t6_digit", digit_out, 15);
        chk("t6_held", key_held, 1);
        tick(1);
        chk("t6_pulse_end", load, 0);
        chk("t6_loads", n_loads - n0, 1);
        keys = 16'h0000;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/keypad_digit_encoder.md
Name: keypad_digit_encoder

Overview:
- Scans a 4x4 active-low matrix keypad and debounces presses.
- Emits each accepted key as a 4-bit digit with a single-cycle load strobe, matching the digit_in/load entry interface of the digital lock.
- Sits between the physical keypad pins and the lock FSM; one load per physical press, no auto-repeat.

Parameters:
- SCAN_DIV, 1000, clock cycles each column is driven (dwell); minimum 2.
- DEBOUNCE_SCANS, 4, consecutive identical full-scan results required to accept a press or a release; minimum 1.

Ports:
- clk  input  1  system clock, all logic rising-edge.
- reset  input  1  synchronous, active-high.
- row_in  input  4  keypad rows, active-low (externally pulled up), pre-synchronised.
- col_out  output  4  column drive, active-low, exactly one bit low at all times.
- digit_out  output  4  code of last accepted key; held until next load.
- load  output  1  one-cycle strobe, digit_out valid in the same cycle.
- key_held  output  1  high while an accepted key is still down (HELD/RELEASE states).

Behaviour:
- Reset values: col_out=4'b1110, digit_out=0, load=0, key_held=0, dwell counter=0, column index=0, debounce counter=0, state IDLE, scan accumulator cleared.
- Scanning: column index c (0..3) advances every SCAN_DIV cycles, wrapping 3->0; col_out = ~(1<<c).
- Sampling: row_in is sampled only in the last cycle of each column dwell. Row r low with column c driven => key (r,c) down.
- Key code: digit_out = {r[1:0], c[1:0]}, i.e. 4*r + c.
- Scan end: the last dwell cycle of column 3. The scan result is classified as NONE (0 keys), SINGLE(code) (exactly 1 key) or MULTI (2 or more keys). The accumulator clears for the next scan.
- All FSM decisions are made at scan end only. Between scan ends the state is frozen.
- IDLE:
  - SINGLE(k) -> cand=k, cnt=1. If DEBOUNCE_SCANS==1, accept immediately; otherwise go to DEBOUNCE.
  - NONE or MULTI -> stay in IDLE.
- DEBOUNCE:
  - SINGLE(cand) -> cnt+1. On reaching DEBOUNCE_SCANS: accept.
  - SINGLE(other k) -> restart with cand=k, cnt=1.
  - NONE or MULTI -> IDLE, cnt=0.
- Accept:
  - The cycle after the scan end, load=1 for exactly one cycle and digit_out=cand (registered), key_held=1.
  - Go to HELD.
- HELD:
  - SINGLE or MULTI -> stay; no further load (no repeat, no rollover).
  - NONE -> RELEASE, cnt=1 (or IDLE directly if DEBOUNCE_SCANS==1).
- RELEASE:
  - NONE -> cnt+1. On reaching DEBOUNCE_SCANS -> IDLE, key_held=0.
  - Any key -> back to HELD, cnt=0.
- key_held falls the cycle after the releasing scan end. A new press is only accepted from IDLE.
- Latency: press stable from scan start -> load exactly DEBOUNCE_SCANS*4*SCAN_DIV + 1 cycles later. A mid-scan press costs up to one extra scan.
- Reset mid-operation: candidate and counters discarded, no load emitted, scan restarts at column 0 with a full dwell.
- digit_out never changes except in a load cycle (or on reset).

Test Plan (SCAN_DIV=4, DEBOUNCE_SCANS=3; one scan = 16 cycles):
1. Assert reset 2 cycles, then observe 40 cycles with row_in=4'hF:
   - Reset values as listed.
   - col_out sequence 1110,1101,1011,0111 with 4 cycles each.
   - load never asserts.
2. Hold key row1/col2 steady from a scan start for 300 cycles:
   - Exactly one load at cycle 49; digit_out=6 (4'b0110).
   - key_held=1 until 3 NONE scans after release, then 0.
3. Bounce: key row0/col1 down for 1 scan, up for 1 scan, repeated 5 times:
   - No load.
   - digit_out stays at its previous value.
4. Press row0/col0 and row2/col3 together for 5 scans:
   - No load (MULTI).
   - Release row0/col0 only: after 3 scans, one load with digit_out=11.
5. Enter 4,3,2,1 ((1,0),(0,3),(0,2),(0,1)), each held 4 scans then released 4 scans:
   - Four loads, digit_out=4,3,2,1 in order, one pulse each.
   - Lock input sequence correct.
6. Press row3/col3, assert reset after 2 matching scans, keep the key down:
   - No load before reset.
   - After reset, col_out=1110.
   - Load with digit_out=15 only after 3 full post-reset scans.
